// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// default data-memory depth.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DM_DEPTH_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Byte and half stores need a read-modify-write; size 3 counts as word.
  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/lane_mux.sv
// Little-endian lane steering: extracts and extends a byte/half for loads, and
// merges a byte/half into a word for read-modify-write stores.
module lane_mux
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] word_in,
  input  logic [31:0] lane_in,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_in[{addr_lo, 3'b000} +: 8];
    half_sel = word_in[{addr_lo[1], 4'b0000} +: 16];

    case (size)
      SZ_BYTE: load_data = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign & half_sel[15]}}, half_sel};
      SZ_WORD, 2'd3: load_data = word_in;
      default: load_data = word_in;
    endcase

    store_word = word_in;
    case (size)
      SZ_BYTE: store_word[{addr_lo, 3'b000} +: 8]    = lane_in[7:0];
      SZ_HALF: store_word[{addr_lo[1], 4'b0000} +: 16] = lane_in[15:0];
      default: store_word = lane_in;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store controller in front of a word-only data memory.
// Optional alignment/range checking is enabled by defining ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DM_DEPTH = DM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_we,
  input  logic [31:0]       dm_rdata
);

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              sign_q, sign_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic        accept;
  logic        misalign;
  logic        out_of_range;
  logic        acc_err;
  logic [31:0] mux_word_in;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept       = req_valid && (state_q == ST_IDLE);
  assign misalign     = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
  assign out_of_range = req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DM_DEPTH);
  assign acc_err      = ALIGN_CHK && (misalign || out_of_range);

  // Loads look at the live read word; the store merge works on the snapshot.
  assign mux_word_in = (state_q == ST_WRITE) ? merge_q : dm_rdata;

  lane_mux u_lane_mux (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .sign       (sign_q),
    .word_in    (mux_word_in),
    .lane_in    (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sign_d  = sign_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: if (accept) begin
        we_d    = req_we;
        sign_d  = req_sign;
        size_d  = req_size;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (acc_err) begin
          state_d = ST_RESP;
          valid_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (!req_we || is_sub_word(req_size)) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: if (we_q) begin
        merge_d = dm_rdata;
        state_d = ST_WRITE;
      end else begin
        rdata_d = load_data;
        state_d = ST_RESP;
        valid_d = 1'b1;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
        valid_d = 1'b1;
        rdata_d = '0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dm_we      = (state_q == ST_WRITE);
  assign dm_wdata   = (state_q == ST_WRITE) ? store_word : '0;
  assign dm_addr    = (state_q == ST_IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller that sits between the CPU memory stage and the word-only data memory (1024 x 32, asynchronous read, write on posedge).
- Accepts one load or store request at a time and handles byte, halfword and word sizes.
- Loads are extracted and sign- or zero-extended from the read word.
- Sub-word stores are done as read-modify-write, because the data memory only supports full-word writes.

Parameters:
- ADDR_W, 32, request/memory address width.
- DM_DEPTH, 1024, data memory depth in words; used only by the alignment/range check.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data; low byte/half used for sub-word stores
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  access error; constant 0 unless ALIGN_CHECK_EN
- dm_addr  output  ADDR_W  word-aligned address to data memory
- dm_wdata  output  32  word to write
- dm_we  output  1  data memory write enable
- dm_rdata  input  32  combinational read data from data memory

Behaviour:
- Handshake
  - Request is accepted on a posedge where req_valid && req_ready.
  - Request fields are captured into internal registers at that edge.
  - There is no backpressure on the response.
  - req_valid while busy is ignored; the requester holds the request until it is accepted.
- Lane selection (little-endian)
  - Byte lane b = addr[1:0] maps to bits [8b+7:8b].
  - Half lane h = addr[1] maps to bits [16h+15:16h].
  - dm_addr = {captured addr[ADDR_W-1:2], 2'b00} in every state except IDLE; in IDLE it is 0.
- FSM states: IDLE, READ, WRITE, RESP.
- Load path: IDLE -> READ -> RESP -> IDLE.
  - In READ, the selected lane of dm_rdata is extended per req_sign and registered into resp_rdata.
- Word store path: IDLE -> WRITE -> RESP -> IDLE.
  - In WRITE, dm_we = 1 and dm_wdata = captured wdata.
- Sub-word store path: IDLE -> READ -> WRITE -> RESP -> IDLE.
  - In READ, dm_rdata is registered into a merge buffer.
  - In WRITE, dm_we = 1 and dm_wdata = merge buffer with only the selected lane replaced by wdata[7:0] or wdata[15:0].
- Latency, counted from the accept edge:
  - Load and word store: resp_valid is high in the 2nd cycle after acceptance.
  - Sub-word store: resp_valid is high in the 3rd cycle after acceptance.
  - resp_valid is high for exactly 1 cycle (the RESP state); req_ready returns high the following cycle.
- Output rules
  - dm_we is high only in WRITE, for exactly one cycle per store; it is never high for loads.
  - resp_rdata holds its value until the next load's READ state; a store's RESP drives resp_rdata = 0.
- Misalignment without the check: low address bits below the access size are ignored.
  - Half: addr[0] is ignored.
  - Word: addr[1:0] are ignored.
- Reset
  - State goes to IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, merge buffer = 0.
  - dm_we = 0 from the first cycle after the reset edge.
  - req_ready = 1 after reset.
  - Reset mid-operation aborts the access; if reset arrives before WRITE, no partial write occurs.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- When defined, at acceptance the unit checks for an error condition:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[ADDR_W-1:2] >= DM_DEPTH.
- On an error: FSM goes IDLE -> RESP directly, with no DM write, resp_rdata = 0 and resp_err = 1 during that resp_valid pulse.
- When not defined: resp_err is tied to 0 and misaligned accesses behave as described under Behaviour.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - FSM state encoding;
  - DM_DEPTH default.
- One natural sub-module, lane_mux: purely combinational.
  - Load mode: extract and extend a lane.
  - Store mode: merge a lane into a word.
  - Mode is selected by size, addr[1:0] and sign.

Test Plan:
- Word store then load:
  - store 0xDEADBEEF at 0x10 -> dm_we pulses once with dm_addr = 0x10; resp_valid 2 cycles after acceptance;
  - lw from 0x10 -> resp_rdata = 0xDEADBEEF.
- Byte store RMW:
  - memory word at 0x20 = 0x11223344; sb 0xAA at 0x22 -> written word 0x11AA3344; resp_valid 3 cycles after acceptance.
- Load extension:
  - word at 0x30 = 0x80FF7F01;
  - lb at 0x32, sign -> 0xFFFFFFFF; lbu at 0x33 -> 0x00000080; lh at 0x32, sign -> 0xFFFF80FF; lhu at 0x30 -> 0x00007F01.
- Busy ignore:
  - hold req_valid through a sub-word store -> req_ready = 0 for 3 cycles; second request accepted only after RESP; exactly one dm_we per store.
- Reset mid-RMW:
  - assert reset during READ of sh 0xBEEF at 0x40 -> no dm_we; word at 0x40 unchanged; resp_valid = 0; req_ready = 1 after reset.
- ALIGN_CHECK_EN:
  - lw at 0x41 -> resp_err = 1, resp_rdata = 0, latency 1 cycle, no DM access;
  - sw to 0x1000 with DM_DEPTH = 1024 -> resp_err = 1, no dm_we.
